pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the single-cycle MIPS datapath: holds PC, computes
//  sequential/branch/jump/register next-PC, supports fetch stall and a fault state for
//  misaligned targets. Feeds the instruction-memory address; redirects come from control/ALU.
// PARAMETERS
//  XLEN          32            PC width in bits (>= 32)
//  RESET_VECTOR  'h0000_0000   PC value loaded on reset (must be 4-byte aligned)
//  RAS_DEPTH     4             return-address-stack entries (used only with PC_RAS_EN), power of 2
// PORTS
//  clk              in   1     clock, rising edge
//  reset            in   1     synchronous, active-high
//  stall            in   1     hold PC this cycle
//  pc_sel           in   2     0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG (pc_sel_e)
//  branch_taken     in   1     qualifies BRANCH; 0 => behaves as SEQ
//  branch_offset    in   XLEN  sign-extended word offset
//  jump_index       in   26    J-type index field
//  jump_reg_target  in   XLEN  register target for JREG
//  link             in   1     JUMP/JREG is a call (RAS push; ignored without PC_RAS_EN)
//  fault_clear      in   1     leave FAULT state
//  pc               out  XLEN  current PC (registered)
//  pc_plus4         out  XLEN  pc + 4, combinational, wraps mod 2^XLEN
//  fault            out  1     registered; 1 while in FAULT
//  fault_pc         out  XLEN  registered; offending target captured on fault entry
// BEHAVIOUR
//  - Reset (any state, any cycle): pc=RESET_VECTOR, state=RUN, fault=0, fault_pc=0, RAS emptied.
//  - Targets: SEQ=pc+4; BRANCH=pc+4+(branch_offset<<2); JUMP={pc_plus4[XLEN-1:28],jump_index,2'b00};
//    JREG=jump_reg_target. All sums truncated to XLEN (wrap, no overflow flag).
//  - FSM RUN: if stall=1 pc holds, no RAS change, no fault check (stall beats redirect;
//    source re-presents redirect). Else if target[1:0]!=0 -> FAULT, fault_pc<=target,
//    pc holds. Else pc<=target next edge (latency 1 cycle).
//  - FSM FAULT: pc, fault_pc hold, all redirects/stall ignored; fault_clear=1 -> RUN next edge
//    with pc<=pc+4 (skip faulting instr). fault_clear in RUN is ignored.
//  - pc 0xFFFF_FFFC + SEQ -> 0x0000_0000.
// CONFIGURATION
//  PC_RAS_EN defined: RAS_DEPTH-entry return-address stack.
//   - JUMP/JREG with link=1 (accepted, non-faulting) pushes pc+4; full => overwrite oldest (circular).
//   - JREG with link=0 and RAS non-empty: pops; target = popped entry (jump_reg_target
//     ignored). Empty => jump_reg_target, no pop.
//   - Push and pop never coincide (link=1 is push-only). Stalled/faulted cycles don't touch RAS.
//  PC_RAS_EN undefined: no stack logic; link ignored; JREG always uses jump_reg_target.
// STRUCTURE
//  pc_pkg: pc_sel_e {PC_SEQ,PC_BRANCH,PC_JUMP,PC_JREG}, pc_state_e {PC_RUN,PC_FAULT}, INSTR_BYTES=4.
//  Sub-module pc_ras (push, pop, push_data, top, empty, full; RAS_DEPTH, XLEN), instantiated
//  only under `ifdef PC_RAS_EN. Next-PC mux and FSM live in pc_unit.
// TESTING
//  1 reset 3 cycles, SEQ x4 -> pc 0,4,8,C,10; re-assert reset at pc=0x10 -> pc=0 next edge.
//  2 pc=0x40, BRANCH taken, offset=-2 -> pc=0x3C; taken=0 -> pc=0x44; stall=1 + BRANCH -> pc 0x40 held.
//  3 pc=0x1000_0000, JUMP jump_index=0x100 -> pc=0x1000_0400; JREG target 0x88 -> pc=0x88.
//  4 JREG target 0x8A -> fault=1, fault_pc=0x8A, pc held 2 cycles under redirects; fault_clear -> pc+4, fault=0.
//  5 pc=0xFFFF_FFFC, SEQ -> pc=0; BRANCH offset=+1 from 0xFFFF_FFF8 -> 0x0000_0000.
//  6 (PC_RAS_EN, depth 4) 5 linked calls from 0x100,0x200,..,0x500; 5 returns -> 0x504,0x404,0x304,0x204,
//    then empty -> jump_reg_target used; without macro, return -> jump_reg_target.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   pc_sel_e    - next-PC source select (SEQ, BRANCH, JUMP, JREG)
//   pc_state_e  - PC FSM state (RUN, FAULT)
//   INSTR_BYTES - instruction size in bytes; sequential step of the PC
//   pc_aligned  - 1 when an address is instruction-aligned
package pc_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JREG   = 2'd3
  } pc_sel_e;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_FAULT = 1'b1
  } pc_state_e;

  // Only the two low bits decide word alignment.
  function automatic logic pc_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack used by pc_unit for call/return prediction.
// Latency: push/pop take effect at the next clock edge; top/empty/full are combinational from state.
// Backpressure: none; pushing while full silently overwrites the oldest entry.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset (empties the stack)
//   push, push_data - write push_data as the new top of stack
//   pop             - discard the top of stack (ignored when empty)
//   top             - current top-of-stack entry (undefined when empty)
//   empty, full     - occupancy flags
module pc_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  // wr_ptr points at the slot the next push writes; the top lives one below.
  // RAS_DEPTH is a power of two, so pointer arithmetic wraps for free.
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   top_idx;
  logic [PW:0]     count;

  assign top_idx = wr_ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      // When full the oldest entry is overwritten, so occupancy stays saturated.
      if (!full) begin
        count <= count + (PW+1)'(1);
      end
    end else if (pop && !empty) begin
      wr_ptr <= top_idx;
      count  <= count - (PW+1)'(1);
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the single-cycle MIPS datapath: holds PC, selects next PC, traps misaligned targets.
// Latency: an accepted redirect or sequential step updates pc at the next clock edge (1 cycle).
// Backpressure: stall=1 holds pc and drops the redirect (source re-presents it); FAULT state ignores all redirects.
//
// Optional feature: define PC_RAS_EN to add a RAS_DEPTH-entry return-address stack
// (JUMP/JREG with link=1 push pc+4, JREG with link=0 pops when non-empty).
//
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   stall            - hold the PC this cycle
//   pc_sel           - next-PC source (pc_sel_e)
//   branch_taken     - qualifies BRANCH; not taken behaves as SEQ
//   branch_offset    - sign-extended word offset for BRANCH
//   jump_index       - J-type 26-bit index for JUMP
//   jump_reg_target  - register target for JREG
//   link             - JUMP/JREG is a call (only meaningful with PC_RAS_EN)
//   fault_clear      - leave FAULT, resuming at the instruction after the faulting one
//   pc, pc_plus4     - current PC (registered) and pc+4 (combinational, wraps)
//   fault, fault_pc  - FAULT indication and the captured misaligned target
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  pc_sel_e         pc_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  input  logic [25:0]     jump_index,
  input  logic [XLEN-1:0] jump_reg_target,
  input  logic            link,
  input  logic            fault_clear,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  pc_state_e       state;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] jreg_target;
  logic [XLEN-1:0] next_target;
  logic            target_ok;
  logic            accept;

  assign pc_plus4      = pc + XLEN'(INSTR_BYTES);
  // Offset is in words; the shift discards its top two bits and the sum wraps.
  assign branch_target = pc_plus4 + (branch_offset << 2);
  // Region bits come from pc+4, as in the classic MIPS J-type encoding.
  assign jump_target   = {pc_plus4[XLEN-1:28], jump_index, 2'b00};

  assign target_ok = pc_aligned(next_target[1:0]);
  // A redirect is taken only in RUN, unstalled and aligned; the RAS follows the same gate.
  assign accept    = (state == PC_RUN) && !stall && target_ok;

`ifdef PC_RAS_EN
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            unused_ras_full;

  // A plain JREG is treated as a return: predicted from the stack when it holds an entry.
  assign jreg_target = (!link && !ras_empty) ? ras_top : jump_reg_target;

  assign ras_push = accept && link && (pc_sel == PC_JUMP || pc_sel == PC_JREG);
  assign ras_pop  = accept && !link && (pc_sel == PC_JREG) && !ras_empty;

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (unused_ras_full)
  );
`else
  logic unused_link;

  assign unused_link = link;
  assign jreg_target = jump_reg_target;
`endif

  always_comb begin
    next_target = pc_plus4;
    case (pc_sel)
      PC_SEQ:    next_target = pc_plus4;
      PC_BRANCH: next_target = branch_taken ? branch_target : pc_plus4;
      PC_JUMP:   next_target = jump_target;
      PC_JREG:   next_target = jreg_target;
      default:   next_target = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PC_RUN;
      pc       <= RESET_VECTOR;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      case (state)
        PC_RUN: begin
          if (accept) begin
            pc <= next_target;
          end else if (!stall) begin
            // Misaligned target: keep pc on the offending instruction and trap.
            state    <= PC_FAULT;
            fault    <= 1'b1;
            fault_pc <= next_target;
          end
        end
        PC_FAULT: begin
          if (fault_clear) begin
            state <= PC_RUN;
            fault <= 1'b0;
            pc    <= pc_plus4;
          end
        end
        default: begin
          state <= PC_RUN;
          fault <= 1'b0;
        end
      endcase
    end
  end

endmodule
